// File: rtl/flash_ctrl_pkg.sv
// Shared constants for the flash command path: operation codes, requester
// indices and arbiter state encodings.
package flash_ctrl_pkg;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_PROG  = 2'd2;
    localparam logic [1:0] OP_ERASE = 2'd3;

    localparam logic [1:0] REQ_READ  = 2'd0;
    localparam logic [1:0] REQ_WRITE = 2'd1;
    localparam logic [1:0] REQ_ERASE = 2'd2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // Requester index order matches op-code order, offset by one.
    function automatic logic [1:0] req_to_op(input logic [1:0] idx);
        case (idx)
            REQ_READ:  return OP_READ;
            REQ_WRITE: return OP_PROG;
            REQ_ERASE: return OP_ERASE;
            default:   return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/flash_op_timer.sv
// Watchdog counter for engine operations: cleared by clr, counts while en,
// and flags expire once it has sat TIMEOUT_CYCLES-1 cycles in the count.
module flash_op_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != LIMIT))
            cnt <= cnt + 16'd1;
    end

    assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/flash_op_arbiter.sv
// Round-robin arbiter sharing the NAND command engine among read, program and
// erase sequencers. FLASH_ARB_TIMEOUT_EN adds a watchdog abort on stuck ops.
module flash_op_arbiter
    import flash_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_read,
    input  logic       req_write,
    input  logic       req_erase,
    input  logic       eng_ready,
    input  logic       eng_done,
    output logic       eng_start,
    output logic [1:0] eng_op,
    output logic       eng_abort,
    output logic       grant_read,
    output logic       grant_write,
    output logic       grant_erase,
    output logic       done_read,
    output logic       done_write,
    output logic       done_erase,
    output logic       timeout_err,
    output logic [1:0] arb_state
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("flash_op_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0] state, state_nxt;
    logic [1:0] win, win_nxt;
    logic [1:0] last;
    logic       done_seen;
    logic       expire;
    logic [2:0] req;
    logic [2:0] grant_q, done_q;
    logic       active_nxt, rel_nxt;
    rr_pick_t   pick;

    // Search starts just past the last winner and wraps through all three.
    function automatic rr_pick_t rr_pick(input logic [2:0] r, input logic [1:0] l);
        rr_pick_t   p;
        logic [1:0] idx;
        p   = '0;
        idx = (l == REQ_ERASE) ? REQ_READ : l + 2'd1;
        for (int i = 0; i < 3; i++) begin
            if (!p.found && r[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
            idx = (idx == REQ_ERASE) ? REQ_READ : idx + 2'd1;
        end
        return p;
    endfunction

    assign req  = {req_erase, req_write, req_read};
    assign pick = rr_pick(req, last);

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        case (state)
            ST_IDLE: begin
                if (eng_ready && pick.found) begin
                    state_nxt = ST_START;
                    win_nxt   = pick.idx;
                end
            end
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A done seen during START is remembered in done_seen.
                if (eng_done || done_seen || expire)
                    state_nxt = ST_RELEASE;
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign active_nxt = (state_nxt != ST_IDLE);
    assign rel_nxt    = (state_nxt == ST_RELEASE);

    // Outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            win       <= REQ_READ;
            last      <= REQ_ERASE;
            done_seen <= 1'b0;
            eng_start <= 1'b0;
            eng_op    <= OP_NONE;
            grant_q   <= '0;
            done_q    <= '0;
        end else begin
            state     <= state_nxt;
            win       <= win_nxt;
            done_seen <= (state == ST_START) && eng_done;
            if (state == ST_RELEASE)
                last <= win;
            eng_start <= (state_nxt == ST_START);
            eng_op    <= active_nxt ? req_to_op(win_nxt) : OP_NONE;
            grant_q   <= active_nxt ? (3'b001 << win_nxt) : 3'b000;
            done_q    <= rel_nxt    ? (3'b001 << win_nxt) : 3'b000;
        end
    end

    assign {grant_erase, grant_write, grant_read} = grant_q;
    assign {done_erase, done_write, done_read}    = done_q;
    assign arb_state = state;

`ifdef FLASH_ARB_TIMEOUT_EN
    logic abort_q;

    flash_op_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == ST_START),
        .en     (state == ST_WAIT),
        .expire (expire)
    );

    // A real completion in the expiry cycle takes precedence over the abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            abort_q <= 1'b0;
        else
            abort_q <= (state == ST_WAIT) && !(eng_done || done_seen) && expire;
    end

    assign eng_abort   = abort_q;
    assign timeout_err = abort_q;
`else
    assign expire      = 1'b0;
    assign eng_abort   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_flash_op_arbiter.sv
// Scoreboard bench for flash_op_arbiter: stimulus queues expected start/done
// events with their cycle, a negedge monitor pops and compares them.
module tb_flash_op_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_read = 1'b0, req_write = 1'b0, req_erase = 1'b0;
    logic       eng_ready = 1'b1, eng_done = 1'b0;
    logic       eng_start, eng_abort, timeout_err;
    logic [1:0] eng_op, arb_state;
    logic       grant_read, grant_write, grant_erase;
    logic       done_read, done_write, done_erase;

    flash_op_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_erase   (req_erase),
        .eng_ready   (eng_ready),
        .eng_done    (eng_done),
        .eng_start   (eng_start),
        .eng_op      (eng_op),
        .eng_abort   (eng_abort),
        .grant_read  (grant_read),
        .grant_write (grant_write),
        .grant_erase (grant_erase),
        .done_read   (done_read),
        .done_write  (done_write),
        .done_erase  (done_erase),
        .timeout_err (timeout_err),
        .arb_state   (arb_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          at;
        logic [10:0] val;
        string       name;
    } exp_t;
    exp_t sb[$];

    // {eng_start, eng_op, grant[e,w,r], done[e,w,r], eng_abort, timeout_err}
    function automatic logic [10:0] ev_start(input int idx);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        return {1'b1, 2'(idx + 1), oh, 3'b000, 2'b00};
    endfunction

    function automatic logic [10:0] ev_done(input int idx, input logic ab);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        return {1'b0, 2'(idx + 1), oh, oh, ab, ab};
    endfunction

    task automatic push(input int at, input logic [10:0] val, input string name);
        exp_t e;
        e.at = at; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        logic [10:0] obs;
        exp_t        e;
        obs = {eng_start, eng_op, grant_erase, grant_write, grant_read,
               done_erase, done_write, done_read, eng_abort, timeout_err};
        if (rst_n && (eng_start || eng_abort || timeout_err || done_read || done_write || done_erase)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: cycle %0d got %03h, expected no event", cyc, obs);
            end else begin
                e = sb.pop_front();
                if (e.at != cyc || e.val !== obs) begin
                    failures++;
                    $display("FAIL %s: cycle %0d value %03h, expected cycle %0d value %03h",
                             e.name, cyc, obs, e.at, e.val);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) go(1);
    endtask

    task automatic set_req(input int idx, input logic v);
        case (idx)
            0: req_read = v;
            1: req_write = v;
            default: req_erase = v;
        endcase
    endtask

    // mode: 0 keep request, 1 drop it in RELEASE, 2 drop it during WAIT.
    // dly 0 pulses eng_done during START; otherwise dly cycles after START.
    task automatic serve(input int idx, input int s, input int dly, input int mode,
                         output int next_s);
        int rel;
        rel = (dly == 0) ? s + 2 : s + dly + 1;
        push(s, ev_start(idx), $sformatf("start_%0d", idx));
        push(rel, ev_done(idx, 1'b0), $sformatf("done_%0d", idx));
        tick_to(s);
        if (dly == 0) eng_done = 1'b1;
        go(1);
        eng_done = 1'b0;
        check("wait_state", {30'd0, arb_state}, 32'd2);
        check("wait_grant", {29'd0, grant_erase, grant_write, grant_read}, 32'd1 << idx);
        check("wait_op", {30'd0, eng_op}, idx + 1);
        if (mode == 2) set_req(idx, 1'b0);
        if (dly > 0) begin
            tick_to(s + dly);
            eng_done = 1'b1;
            go(1);
            eng_done = 1'b0;
        end
        tick_to(rel);
        if (mode == 1) set_req(idx, 1'b0);
        go(1);
        check("grant_drop", {27'd0, grant_erase, grant_write, grant_read, eng_op}, 32'd0);
        next_s = rel + 2;
    endtask

    initial begin : stim
        int s;
        go(2);
        check("reset_outputs", {19'd0, eng_start, eng_op, grant_erase, grant_write, grant_read,
              done_erase, done_write, done_read, eng_abort, timeout_err, arb_state}, 32'd0);
        rst_n = 1'b1;
        go(1);

        // All three request at once after reset: read, write, erase, read.
        req_read = 1'b1; req_write = 1'b1; req_erase = 1'b1;
        s = cyc + 1;
        serve(0, s, 0, 0, s);
        serve(1, s, 2, 1, s);
        serve(2, s, 3, 1, s);
        serve(0, s, 1, 1, s);
        go(1);

        // Reset during WAIT: outputs clear at once and no done appears.
        req_write = 1'b1;
        s = cyc + 1;
        push(s, ev_start(1), "start_pre_reset");
        tick_to(s + 2);
        check("pre_reset_grant", {31'd0, grant_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_midop", {19'd0, eng_start, eng_op, grant_erase, grant_write, grant_read,
              done_erase, done_write, done_read, eng_abort, timeout_err, arb_state}, 32'd0);
        req_read = 1'b1;
        go(2);
        rst_n = 1'b1;
        s = cyc + 1;
        serve(0, s, 3, 1, s);
        serve(1, s, 2, 1, s);
        go(1);

        // Engine busy holds off any grant; write withdraws during WAIT.
        eng_ready = 1'b0;
        req_write = 1'b1; req_erase = 1'b1;
        for (int i = 0; i < 10; i++) begin
            go(1);
            check("busy_idle", {28'd0, eng_start, grant_erase, grant_write, grant_read}, 32'd0);
        end
        eng_ready = 1'b1;
        s = cyc + 1;
        serve(2, s, 1, 1, s);
        serve(1, s, 4, 2, s);
        go(1);

        // Single read, engine completes five cycles after start.
        req_read = 1'b1;
        s = cyc + 1;
        serve(0, s, 5, 1, s);
        go(1);

`ifdef FLASH_ARB_TIMEOUT_EN
        req_erase = 1'b1;
        s = cyc + 1;
        push(s, ev_start(2), "wd_start");
        push(s + 9, ev_done(2, 1'b1), "wd_abort");
        tick_to(s + 9);
        req_erase = 1'b0;
        go(2);
        check("wd_idle", {28'd0, grant_erase, arb_state, eng_abort}, 32'd0);
`else
        req_erase = 1'b1;
        s = cyc + 1;
        serve(2, s, 20, 1, s);
`endif

        go(3);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : time_bound
        #200000;
        failures++;
        $display("FAIL time_limit: simulation still running at %0t, expected finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
